// File: rtl/branch_resolve_stage.sv
// branch_resolve_stage: two-stage pipelined RV32 branch resolution with valid/ready flow control
module branch_resolve_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [N-1:0]     in_rs1,
    input  logic [N-1:0]     in_rs2,
    input  logic [N-1:0]     in_pc,
    input  logic [N-1:0]     in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [N-1:0]     out_target,
    output logic [N-1:0]     out_next_pc,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    logic         s1_valid;
    logic [2:0]   s1_funct3;
    logic [N-1:0] s1_rs1, s1_rs2, s1_pc, s1_imm;
    logic         s2_valid, s2_taken, s2_illegal;
    logic [N-1:0] s2_target, s2_next_pc;
    logic         adv1, adv2, fire;
    logic         eq, lts, ltu, cond, illegal, taken;
    logic [N-1:0] target, pc4, next_pc;

    assign adv2        = ~s2_valid | out_ready;
    assign adv1        = ~s1_valid | adv2;
    assign in_ready    = adv1;
    assign fire        = s2_valid & out_ready & ~flush;
    assign out_valid   = s2_valid;
    assign out_taken   = s2_taken;
    assign out_illegal = s2_illegal;
    assign out_target  = s2_target;
    assign out_next_pc = s2_next_pc;

    // Resolve the op held in S1: compare operands, decode funct3, form both candidate PCs
    always_comb begin
        eq      = s1_rs1 == s1_rs2;
        lts     = $signed(s1_rs1) < $signed(s1_rs2);
        ltu     = s1_rs1 < s1_rs2;
        target  = s1_pc + s1_imm;
        pc4     = s1_pc + N'(4);
        illegal = s1_funct3[2:1] == 2'b01;
        cond    = s1_funct3[2] ? (s1_funct3[1] ? ltu : lts) : eq;
        taken   = ~illegal & (cond ^ s1_funct3[0]);
        next_pc = taken ? target : pc4;
    end

    // Pipeline registers: S1 captures the raw op, S2 captures the resolved result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_funct3  <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_pc      <= '0;
            s1_imm     <= '0;
            s2_valid   <= 1'b0;
            s2_taken   <= 1'b0;
            s2_illegal <= 1'b0;
            s2_target  <= '0;
            s2_next_pc <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_funct3 <= in_funct3;
                    s1_rs1    <= in_rs1;
                    s1_rs2    <= in_rs2;
                    s1_pc     <= in_pc;
                    s1_imm    <= in_imm;
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_taken   <= taken;
                    s2_illegal <= illegal;
                    s2_target  <= target;
                    s2_next_pc <= next_pc;
                end
            end
        end
    end

    // Saturating performance counters, bumped only on a completed downstream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_cnt <= '0;
            taken_cnt    <= '0;
        end else if (fire) begin
            if (resolved_cnt != '1) resolved_cnt <= resolved_cnt + CNT_W'(1);
            if (s2_taken && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve_stage.sv
// tb_branch_resolve_stage: scoreboard bench for branch_resolve_stage
`timescale 1ns/1ps
module tb_branch_resolve_stage;
    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic [31:0] target;
        logic [31:0] next_pc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken, out_illegal;
    logic [31:0] out_target, out_next_pc;
    logic [3:0]  resolved_cnt, taken_cnt;

    int   passed = 0;
    int   total = 0;
    int   n_out = 0;
    res_t q[$];
    logic [3:0] exp_res = '0;
    logic [3:0] exp_tak = '0;

    branch_resolve_stage #(.N(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_illegal(out_illegal), .out_target(out_target), .out_next_pc(out_next_pc),
        .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [2:0] f, input logic [31:0] a, b, pc, imm);
        res_t r;
        case (f)
            3'b000:  r.taken = (a == b);
            3'b001:  r.taken = (a != b);
            3'b100:  r.taken = ($signed(a) < $signed(b));
            3'b101:  r.taken = ($signed(a) >= $signed(b));
            3'b110:  r.taken = (a < b);
            3'b111:  r.taken = (a >= b);
            default: r.taken = 1'b0;
        endcase
        r.illegal = (f == 3'b010) || (f == 3'b011);
        r.target  = pc + imm;
        r.next_pc = r.taken ? r.target : pc + 32'd4;
        return r;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else begin
                if (in_valid && in_ready) q.push_back(model(in_funct3, in_rs1, in_rs2, in_pc, in_imm));
                if (out_valid && out_ready) begin
                    res_t act, e;
                    act = {out_taken, out_illegal, out_target, out_next_pc};
                    total++;
                    if (q.size() == 0) begin
                        $display("FAIL scoreboard_unexpected: got %h with nothing expected", act);
                    end else begin
                        e = q.pop_front();
                        if (act !== e) $display("FAIL scoreboard: got %h expected %h", act, e);
                        else passed++;
                    end
                    n_out++;
                    if (exp_res != 4'hF) exp_res = exp_res + 4'd1;
                    if (act.taken && exp_tak != 4'hF) exp_tak = exp_tak + 4'd1;
                end
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] a, b, pc, imm);
        logic ok;
        int n;
        in_valid = 1'b1; in_funct3 = f; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm;
        n = 0;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 100);
        if (!ok) begin
            total++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        #1;
        total++;
        if (q.size() !== 0) $display("FAIL drain: %0d results outstanding, required 0", q.size());
        else passed++;
    endtask

    task automatic chk_counters(input string name);
        total++;
        if ({resolved_cnt, taken_cnt} !== {exp_res, exp_tak})
            $display("FAIL %s: counters %0d/%0d, required %0d/%0d", name, resolved_cnt, taken_cnt, exp_res, exp_tak);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, out_taken, out_illegal} !== 4'b0100)
            $display("FAIL reset_ctrl: valid/ready/taken/illegal %b%b%b%b, required 0100", out_valid, in_ready, out_taken, out_illegal);
        else passed++;
        total++;
        if ({out_target, out_next_pc} !== 64'h0)
            $display("FAIL reset_data: target %h next %h, required 0", out_target, out_next_pc);
        else passed++;
        chk_counters("reset_counters");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_beq_latency();
        send(3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20);
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_taken, out_illegal, out_target, out_next_pc} !== {3'b110, 32'h120, 32'h120})
            $display("FAIL beq: v/t/i %b%b%b target %h next %h, required 110 00000120 00000120",
                     out_valid, out_taken, out_illegal, out_target, out_next_pc);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({out_valid, resolved_cnt, taken_cnt} !== {1'b0, 4'd1, 4'd1})
            $display("FAIL beq_counters: valid %b cnt %0d/%0d, required 0 1/1", out_valid, resolved_cnt, taken_cnt);
        else passed++;
    endtask

    task automatic test_compare();
        send(3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40);
        send(3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40);
        send(3'b101, 32'hFFFFFFFF, 32'h1, 32'h300, 32'hFFFFFFF0);
        send(3'b111, 32'hFFFFFFFF, 32'h1, 32'h300, 32'hFFFFFFF0);
        send(3'b001, 32'h55, 32'h55, 32'h400, 32'h8);
        send(3'b000, 32'h55, 32'h56, 32'h400, 32'h8);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            a = $urandom;
            send(3'($urandom_range(0, 7)), a, (i % 3 == 0) ? a : $urandom, $urandom, $urandom);
        end
        wait_drain();
    endtask

    task automatic test_illegal_wrap();
        send(3'b010, 32'h7, 32'h7, 32'h500, 32'h10);
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_taken, out_illegal, out_next_pc} !== {3'b101, 32'h504})
            $display("FAIL illegal: v/t/i %b%b%b next %h, required 101 00000504", out_valid, out_taken, out_illegal, out_next_pc);
        else passed++;
        send(3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8);
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_target, out_next_pc} !== {1'b1, 32'h4, 32'h4})
            $display("FAIL wrap: valid %b target %h next %h, required 1 00000004 00000004", out_valid, out_target, out_next_pc);
        else passed++;
        send(3'b011, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h8);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int start = n_out;
        fork
            for (int i = 0; i < 8; i++)
                send(3'(i), 32'(i * 3), 32'(7 - i), 32'h1000 + 32'(i * 4), 32'h40);
            begin
                res_t snap;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                snap = {out_taken, out_illegal, out_target, out_next_pc};
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    total++;
                    if (!out_valid || {out_taken, out_illegal, out_target, out_next_pc} !== snap)
                        $display("FAIL stall_hold: valid %b data %h, required 1 %h", out_valid,
                                 {out_taken, out_illegal, out_target, out_next_pc}, snap);
                    else passed++;
                    if (c == 0) begin
                        total++;
                        if (in_ready !== 1'b0) $display("FAIL stall_ready: in_ready %b, required 0", in_ready);
                        else passed++;
                    end
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        total++;
        if (n_out - start !== 8) $display("FAIL b2b_count: %0d results, required 8", n_out - start);
        else passed++;
    endtask

    task automatic test_flush();
        logic [3:0] r0, t0;
        send(3'b000, 32'h1, 32'h1, 32'h600, 32'h20);
        send(3'b001, 32'h1, 32'h2, 32'h700, 32'h20);
        r0 = resolved_cnt; t0 = taken_cnt;
        flush = 1'b1;
        in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 0; in_rs2 = 0; in_pc = 32'h800; in_imm = 32'h4;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if ({out_valid, resolved_cnt, taken_cnt} !== {1'b0, r0, t0})
            $display("FAIL flush: valid %b cnt %0d/%0d, required 0 %0d/%0d", out_valid, resolved_cnt, taken_cnt, r0, t0);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL flush_drop: valid %b, required 0", out_valid);
        else passed++;
        send(3'b110, 32'h3, 32'h9, 32'h900, 32'h100);
        wait_drain();
        chk_counters("flush_after");
    endtask

    task automatic test_saturate_reset();
        rst_n = 1'b0;
        #2;
        exp_res = '0; exp_tak = '0; q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) send(3'b001, 32'(i), 32'h3, 32'h40 * 32'(i), 32'h10);
        wait_drain();
        total++;
        if (resolved_cnt !== 4'd15) $display("FAIL saturate: resolved_cnt %0d, required 15", resolved_cnt);
        else passed++;
        chk_counters("saturate_model");
        in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 0; in_rs2 = 0; in_pc = 32'hA00; in_imm = 32'h8;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, resolved_cnt, taken_cnt} !== 9'h0)
            $display("FAIL async_reset: valid %b cnt %0d/%0d, required 0 0/0", out_valid, resolved_cnt, taken_cnt);
        else passed++;
        in_valid = 1'b0; q.delete(); exp_res = '0; exp_tak = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL post_reset: valid/ready %b%b, required 01", out_valid, in_ready);
        else passed++;
        chk_counters("post_reset_counters");
    endtask

    initial begin
        test_reset();
        test_beq_latency();
        test_compare();
        test_illegal_wrap();
        test_back_to_back();
        test_flush();
        test_saturate_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
